qea_host_sequencer: RTL and testbench

Hardware host controller that drives the QEA core's load/start/readout ports. It performs the same session a host performs by hand: write gate-context words from an input stream into context RAM, initialise state RAM to |0…0⟩, pulse start, wait for completion, then stream the final state vector out. It sits between a DMA/stream fabric and one QEA instance.

---
 rtl/qea_host_sequencer.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_qea_host_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: host-side session controller for one QEA core.
// Loads context words, initialises state RAM to |0..0>, starts the core,
// waits for completion and streams the state vector out.
// Ports: clk/rst (sync, active high); i_go/i_qbit_num/i_ins_num session
// request; s_ctx_* context stream in; m_state_* state stream out;
// o_busy/o_done/o_run_cycles status; o_qea_*/o_ctx_*/o_state_* drive the
// core; i_qea_complete/i_qea_state_dout come back from it.
// Build option: QEA_HOST_CYCLE_COUNT_EN adds the run-cycle counter.
module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LATENCY              = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_go,
  input  logic [MAX_QBIT_WIDTH-1:0] i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num,
  input  logic s_ctx_valid,
  output logic s_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0] s_ctx_data,
  output logic m_state_valid,
  input  logic m_state_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] m_state_data,
  output logic m_state_last,
  output logic o_busy,
  output logic o_done,
  output logic [31:0] o_run_cycles,
  output logic o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0] o_qea_qbit_num,
  output logic o_ctx_en,
  output logic o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data,
  output logic [PE_NUM-1:0] o_state_ena,
  output logic [PE_NUM-1:0] o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0] o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0] o_state_dina,
  input  logic i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_qea_state_dout
);

  localparam int SW = PE_NUM * STATE_DATA_WIDTH;
  localparam int CW = STATE_ADDR_WIDTH + 1;
  localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DATA_WIDTH-1:0] ONE =
    DATA_WIDTH'(1) << NUM_FRAC_BIT;
  // amplitude 1.0 sits in the real field of the top lane
  localparam logic [SW-1:0] INIT_W0 = {ONE, {(SW-DATA_WIDTH){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, INIT_STATE, START, RUN,
    RD_REQ, RD_WAIT, RD_OUT, DONE
  } state_t;

  state_t state_q, state_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_q, ins_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_cnt_q, ctx_cnt_d;
  logic [CW-1:0] nw_q, nw_d;
  logic [CW-1:0] w_q, w_d;
  logic [WW-1:0] wait_q, wait_d;
  logic first_q, first_d;
  logic [MAX_QBIT_WIDTH-1:0] qbit_d;

  logic ctx_ready_d, ctx_en_d;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_d;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_d;
  logic [PE_NUM-1:0] st_ena_d, st_wea_d;
  logic [STATE_ADDR_WIDTH-1:0] st_addr_d;
  logic [SW-1:0] st_din_d, data_d;
  logic start_d, valid_d, last_d, done_d, busy_d;

  // word count clamps at the RAM depth for oversized qubit counts
  function automatic logic [CW-1:0] calc_nw(
    input logic [MAX_QBIT_WIDTH-1:0] q
  );
    logic [MAX_QBIT_WIDTH-1:0] sh;
    sh = q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    if (q <= MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
      calc_nw = CW'(1);
    else if (sh >= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH))
      calc_nw = CW'(1) << STATE_ADDR_WIDTH;
    else
      calc_nw = CW'(1) << sh;
  endfunction

  always_comb begin
    state_d     = state_q;
    ins_d       = ins_q;
    ctx_cnt_d   = ctx_cnt_q;
    nw_d        = nw_q;
    w_d         = w_q;
    wait_d      = wait_q;
    first_d     = 1'b0;
    qbit_d      = o_qea_qbit_num;
    ctx_ready_d = 1'b0;
    ctx_en_d    = 1'b0;
    ctx_addr_d  = o_ctx_addr;
    ctx_data_d  = o_ctx_data;
    st_ena_d    = '0;
    st_wea_d    = '0;
    st_addr_d   = o_state_addra;
    st_din_d    = o_state_dina;
    data_d      = m_state_data;
    start_d     = 1'b0;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_go) begin
          qbit_d    = i_qbit_num;
          ins_d     = i_ins_num;
          nw_d      = calc_nw(i_qbit_num);
          ctx_cnt_d = '0;
          w_d       = '0;
          if (i_ins_num == '0) begin
            state_d  = INIT_STATE;
            st_ena_d = '1;
            st_wea_d = '1;
            st_addr_d = '0;
            st_din_d = INIT_W0;
          end else begin
            state_d     = LOAD_CTX;
            ctx_ready_d = 1'b1;
          end
        end
      end
      LOAD_CTX: begin
        ctx_ready_d = 1'b1;
        if (s_ctx_valid && s_ctx_ready) begin
          ctx_en_d   = 1'b1;
          ctx_addr_d = ctx_cnt_q;
          ctx_data_d = s_ctx_data;
          ctx_cnt_d  = ctx_cnt_q + 1'b1;
          if (ctx_cnt_q + 1'b1 == ins_q) begin
            ctx_ready_d = 1'b0;
            state_d     = INIT_STATE;
            st_ena_d    = '1;
            st_wea_d    = '1;
            st_addr_d   = '0;
            st_din_d    = INIT_W0;
          end
        end
      end
      INIT_STATE: begin
        if (w_q + 1'b1 == nw_q) begin
          state_d = START;
          start_d = 1'b1;
          w_d     = '0;
        end else begin
          w_d       = w_q + 1'b1;
          st_ena_d  = '1;
          st_wea_d  = '1;
          st_addr_d = STATE_ADDR_WIDTH'(w_q + 1'b1);
          st_din_d  = '0;
        end
      end
      START: begin
        state_d = RUN;
        first_d = 1'b1;
      end
      RUN: begin
        // complete may still be high from the last run on cycle one
        if (!first_q && i_qea_complete) begin
          state_d   = RD_REQ;
          st_ena_d  = '1;
          st_addr_d = STATE_ADDR_WIDTH'(w_q);
        end
      end
      RD_REQ: begin
        state_d = RD_WAIT;
        wait_d  = '0;
      end
      RD_WAIT: begin
        if (wait_q == WW'(RD_LATENCY - 1)) begin
          state_d = RD_OUT;
          data_d  = i_qea_state_dout;
          valid_d = 1'b1;
          last_d  = (w_q + 1'b1 == nw_q);
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RD_OUT: begin
        if (m_state_ready) begin
          if (w_q + 1'b1 == nw_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            w_d       = w_q + 1'b1;
            state_d   = RD_REQ;
            st_ena_d  = '1;
            st_addr_d = STATE_ADDR_WIDTH'(w_q + 1'b1);
          end
        end else begin
          valid_d = 1'b1;
          last_d  = m_state_last;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ins_q          <= '0;
      ctx_cnt_q      <= '0;
      nw_q           <= '0;
      w_q            <= '0;
      wait_q         <= '0;
      first_q        <= 1'b0;
      o_qea_qbit_num <= '0;
      s_ctx_ready    <= 1'b0;
      o_ctx_en       <= 1'b0;
      o_ctx_wea      <= 1'b0;
      o_ctx_addr     <= '0;
      o_ctx_data     <= '0;
      o_state_ena    <= '0;
      o_state_wea    <= '0;
      o_state_addra  <= '0;
      o_state_dina   <= '0;
      m_state_data   <= '0;
      m_state_valid  <= 1'b0;
      m_state_last   <= 1'b0;
      o_qea_start    <= 1'b0;
      o_done         <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ins_q          <= ins_d;
      ctx_cnt_q      <= ctx_cnt_d;
      nw_q           <= nw_d;
      w_q            <= w_d;
      wait_q         <= wait_d;
      first_q        <= first_d;
      o_qea_qbit_num <= qbit_d;
      s_ctx_ready    <= ctx_ready_d;
      o_ctx_en       <= ctx_en_d;
      o_ctx_wea      <= ctx_en_d;
      o_ctx_addr     <= ctx_addr_d;
      o_ctx_data     <= ctx_data_d;
      o_state_ena    <= st_ena_d;
      o_state_wea    <= st_wea_d;
      o_state_addra  <= st_addr_d;
      o_state_dina   <= st_din_d;
      m_state_data   <= data_d;
      m_state_valid  <= valid_d;
      m_state_last   <= last_d;
      o_qea_start    <= start_d;
      o_done         <= done_d;
      o_busy         <= busy_d;
    end
  end

`ifdef QEA_HOST_CYCLE_COUNT_EN
  logic [31:0] run_q;

  always_ff @(posedge clk) begin
    if (rst)
      run_q <= '0;
    else if (state_q == START)
      run_q <= '0;
    else if (state_q == RUN && run_q != '1)
      run_q <= run_q + 1'b1;
  end

  assign o_run_cycles = run_q;
`else
  assign o_run_cycles = '0;
`endif

endmodule

// File: tb/tb_qea_host_sequencer.sv
// tb_qea_host_sequencer: directed sessions with random data against a
// behavioural QEA/RAM model; covers gaps, backpressure and mid-run reset.
module tb_qea_host_sequencer;
  localparam int PW  = 2;
  localparam int QW  = 6;
  localparam int CAW = 16;
  localparam int CDW = 64;
  localparam int SAW = 16;
  localparam int SW  = 256;
  localparam int L   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_go = 1'b0;
  logic [QW-1:0] i_qbit_num = '0;
  logic [CAW-1:0] i_ins_num = '0;
  logic s_ctx_valid = 1'b0;
  logic s_ctx_ready;
  logic [CDW-1:0] s_ctx_data = '0;
  logic m_state_valid;
  logic m_state_ready = 1'b0;
  logic [SW-1:0] m_state_data;
  logic m_state_last;
  logic o_busy, o_done;
  logic [31:0] o_run_cycles;
  logic o_qea_start;
  logic [QW-1:0] o_qea_qbit_num;
  logic o_ctx_en, o_ctx_wea;
  logic [CAW-1:0] o_ctx_addr;
  logic [CDW-1:0] o_ctx_data;
  logic [3:0] o_state_ena, o_state_wea;
  logic [SAW-1:0] o_state_addra;
  logic [SW-1:0] o_state_dina;
  logic i_qea_complete = 1'b0;
  logic [SW-1:0] i_qea_state_dout = '0;

  qea_host_sequencer dut (
    .clk(clk), .rst(rst), .i_go(i_go),
    .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready),
    .s_ctx_data(s_ctx_data),
    .m_state_valid(m_state_valid), .m_state_ready(m_state_ready),
    .m_state_data(m_state_data), .m_state_last(m_state_last),
    .o_busy(o_busy), .o_done(o_done), .o_run_cycles(o_run_cycles),
    .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea),
    .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
    .o_state_addra(o_state_addra), .o_state_dina(o_state_dina),
    .i_qea_complete(i_qea_complete),
    .i_qea_state_dout(i_qea_state_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [SW-1:0] mem [0:63];
  logic [SW-1:0] pipe [0:L-1];
  logic [SW-1:0] init_w0;
  bit acc_prev = 0;
  logic [CAW-1:0] acc_addr;
  logic [CDW-1:0] acc_data;
  int ctx_idx = 0;
  int cur_ins = 0;
  int init_cnt = 0;
  int last_wr_cyc = 0;

  task automatic chk(input string tag, input logic [SW-1:0] got,
                     input logic [SW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] rnd_word();
    logic [SW-1:0] w;
    for (int i = 0; i < SW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // one clock: apply RAM/ctx effects of this cycle, then advance
  task automatic step();
    logic [SW-1:0] rd_in;
    chk("ctx_en", o_ctx_en, acc_prev);
    if (acc_prev) begin
      chk("ctx_wea", o_ctx_wea, 1);
      chk("ctx_addr", o_ctx_addr, acc_addr);
      chk("ctx_data", o_ctx_data, acc_data);
    end
    chk("ctx_rdy_bound", s_ctx_ready && (ctx_idx >= cur_ins), 0);
    acc_prev = s_ctx_valid && s_ctx_ready && !rst;
    if (acc_prev) begin
      acc_addr = CAW'(ctx_idx);
      acc_data = s_ctx_data;
      ctx_idx++;
    end
    rd_in = rnd_word();
    if (o_state_ena == 4'hf && o_state_wea == 4'hf) begin
      chk("init_addr", o_state_addra, init_cnt);
      mem[o_state_addra[5:0]] = o_state_dina;
      init_cnt++;
      last_wr_cyc = cyc;
    end else if (o_state_ena == 4'hf && o_state_wea == 4'h0) begin
      rd_in = mem[o_state_addra[5:0]];
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = rd_in;
    i_qea_state_dout = pipe[L-1];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_go = 1'b0;
    s_ctx_valid = 1'b0;
    i_qea_complete = 1'b0;
    m_state_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_all_zero", |{s_ctx_ready, m_state_valid, m_state_data,
        m_state_last, o_busy, o_done, o_run_cycles, o_qea_start,
        o_qea_qbit_num, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
        o_state_ena, o_state_wea, o_state_addra, o_state_dina}, 0);
    repeat (3) begin
      chk("rst_idle", {o_busy, o_state_ena, o_ctx_en}, 0);
      step();
    end
  endtask

  // abort: 0 none, 1 reset in RUN, 2 reset while second word is offered
  task automatic session(input int qbit, input int ins, input int gap,
                         input int rdy_rand, input int dly,
                         input int abort);
    int nw, exp_run, out_idx, start_cyc, starts, last_hs;
    bit done_seen, hold, aborted;
    logic [SW-1:0] hold_data;
    logic hold_last;
    logic [CDW-1:0] ctxw [$];
    logic [SW-1:0] expw [$];
    nw = (qbit <= PW) ? 1 : (1 << (qbit - PW));
`ifdef QEA_HOST_CYCLE_COUNT_EN
    exp_run = (dly < 2) ? 2 : dly;
`else
    exp_run = 0;
`endif
    for (int k = 0; k < ins; k++) ctxw.push_back({$urandom, $urandom});
    out_idx = 0; starts = 0; start_cyc = 0; last_hs = 0;
    done_seen = 0; hold = 0; aborted = 0;
    hold_data = '0; hold_last = 1'b0;
    cur_ins = ins; ctx_idx = 0; init_cnt = 0; acc_prev = 0;
    i_go = 1'b1;
    i_qbit_num = QW'(qbit);
    i_ins_num = CAW'(ins);
    step();
    chk("go_busy", o_busy, 1);
    chk("go_ctx_ready", s_ctx_ready, ins > 0);
    chk("go_qbit", o_qea_qbit_num, qbit);
    for (int b = 0; b < 5000 && !done_seen && !aborted; b++) begin
      i_go = 1'($urandom_range(0, 1));
      i_qbit_num = QW'($urandom);
      i_ins_num = CAW'($urandom);
      s_ctx_valid = (ctx_idx < ins) && (gap == 0 || cyc % 3 != 0);
      s_ctx_data = s_ctx_valid ? ctxw[ctx_idx] : CDW'($urandom);
      if (o_qea_start) begin
        starts++;
        if (starts == 1) begin
          start_cyc = cyc;
          chk("init_count", init_cnt, nw);
          chk("init_word0", mem[0], init_w0);
          chk("init_wordN", mem[nw-1], (nw > 1) ? '0 : init_w0);
          chk("start_after_init", last_wr_cyc, cyc - 1);
          for (int i = 0; i < nw; i++) begin
            mem[i] = rnd_word();
            expw.push_back(mem[i]);
          end
        end
      end
      i_qea_complete = (starts > 0) && (cyc >= start_cyc + dly);
      m_state_ready = (rdy_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("last_wo_valid", m_state_last & ~m_state_valid, 0);
      if (hold) begin
        chk("hold_valid", m_state_valid, 1);
        chk("hold_data", m_state_data, hold_data);
        chk("hold_last", m_state_last, hold_last);
      end
      if (abort == 1 && starts > 0 && cyc == start_cyc + 3) begin
        aborted = 1;
      end else if (abort == 2 && m_state_valid && out_idx == 1) begin
        aborted = 1;
      end else if (m_state_valid) begin
        if (out_idx < expw.size())
          chk("out_data", m_state_data, expw[out_idx]);
        else
          chk("out_extra", out_idx, expw.size() - 1);
        chk("out_last", m_state_last, out_idx == nw - 1);
        hold = !m_state_ready;
        hold_data = m_state_data;
        hold_last = m_state_last;
        if (m_state_ready) begin
          if (rdy_rand == 0 && out_idx > 0)
            chk("word_gap", cyc - last_hs, L + 2);
          last_hs = cyc;
          out_idx++;
        end
      end else begin
        hold = 0;
      end
      if (o_done) begin
        done_seen = 1;
        i_go = 1'b0;
        chk("done_timing", cyc, last_hs + 1);
        chk("word_count", out_idx, nw);
        chk("start_pulses", starts, 1);
        chk("run_cycles", o_run_cycles, exp_run);
        chk("qbit_hold", o_qea_qbit_num, qbit);
      end
      if (!aborted) step();
    end
    i_go = 1'b0;
    s_ctx_valid = 1'b0;
    if (aborted) begin
      do_reset();
    end else begin
      chk("done_seen", done_seen, 1);
      chk("done_pulse", o_done, 0);
      chk("idle_busy", o_busy, 0);
    end
  endtask

  initial begin
    init_w0 = '0;
    init_w0[SW-1 -: 32] = 32'h4000_0000;
    for (int i = 0; i < L; i++) pipe[i] = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outs", |{s_ctx_ready, m_state_valid, m_state_data,
        m_state_last, o_busy, o_done, o_run_cycles, o_qea_start,
        o_qea_qbit_num, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
        o_state_ena, o_state_wea, o_state_addra, o_state_dina}, 0);
    chk("reset_busy", o_busy, 0);
    session(7, 145, 0, 0, 10, 0);
    session(2, 0, 0, 0, 4, 0);
    session(5, 20, 1, 1, 1, 0);
    session(6, 8, 0, 1, 50, 1);
    session(4, 3, 0, 0, 5, 0);
    session(3, 5, 1, 0, 3, 2);
    session(1, 2, 0, 1, 7, 0);
    session(6, 12, 1, 1, 12, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
